// File: rtl/lcd_writer.sv
// HD44780 8-bit writer: power-up wait, init command sequence, then a full
// two-line 32-character refresh each time buffer_ready rises.
module lcd_writer #(
    parameter int unsigned POWERUP_WAIT = 1500000,
    parameter int unsigned SETUP_CYC    = 4,
    parameter int unsigned E_PULSE      = 50,
    parameter int unsigned CMD_WAIT     = 4000,
    parameter int unsigned CLEAR_WAIT   = 164000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       buffer_ready,
    input  logic [7:0] char_in,
    output logic [5:0] sel,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic       busy
);

    localparam int unsigned MAX_A   = (POWERUP_WAIT > SETUP_CYC) ? POWERUP_WAIT : SETUP_CYC;
    localparam int unsigned MAX_B   = (E_PULSE > CMD_WAIT) ? E_PULSE : CMD_WAIT;
    localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_ALL = (MAX_AB > CLEAR_WAIT) ? MAX_AB : CLEAR_WAIT;
    localparam int unsigned CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] PWR_LAST   = CW'(POWERUP_WAIT - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EHIGH_LAST = CW'(E_PULSE - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLEAR_WAIT - 1);

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_IDLE, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2
    } state_t;

    typedef enum logic [1:0] {
        P_FETCH, P_SETUP, P_EHIGH, P_WAIT
    } phase_t;

    state_t        state_q;
    phase_t        phase_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    init_idx_q;
    logic [5:0]    sel_q;
    logic          rs_q;
    logic          e_q;
    logic [7:0]    db_q;
    logic          busy_q;
    logic          clr_q;
    logic          req_q;
    logic          br_prev_q;

    logic          br_rise;
    logic          take_req;
    logic          req_d;
    logic [CW-1:0] wait_last;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return 8'h38;
            3'd3:             return 8'h0C;
            3'd4:             return 8'h06;
            default:          return 8'h01;
        endcase
    endfunction

    // A rising edge arriving in the same cycle IDLE consumes req re-arms it,
    // so that request is served by one further refresh.
    assign br_rise   = buffer_ready & ~br_prev_q;
    assign take_req  = (state_q == S_IDLE) && req_q;
    assign req_d     = (req_q & ~take_req) | br_rise;
    assign wait_last = clr_q ? CLR_LAST : CMD_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_PWRUP;
            phase_q    <= P_SETUP;
            cnt_q      <= '0;
            init_idx_q <= '0;
            sel_q      <= '0;
            rs_q       <= 1'b0;
            e_q        <= 1'b0;
            db_q       <= '0;
            busy_q     <= 1'b1;
            clr_q      <= 1'b0;
            req_q      <= 1'b0;
            br_prev_q  <= 1'b0;
        end else begin
            br_prev_q <= buffer_ready;
            req_q     <= req_d;
            case (state_q)
                S_PWRUP: begin
                    if (cnt_q == PWR_LAST) begin
                        state_q    <= S_INIT;
                        phase_q    <= P_SETUP;
                        cnt_q      <= '0;
                        init_idx_q <= '0;
                        rs_q       <= 1'b0;
                        db_q       <= init_cmd(3'd0);
                        clr_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req_q) begin
                        state_q <= S_ADDR1;
                        busy_q  <= 1'b1;
                        phase_q <= P_SETUP;
                        cnt_q   <= '0;
                        rs_q    <= 1'b0;
                        db_q    <= 8'h80;
                        clr_q   <= 1'b0;
                    end
                end
                default: begin
                    case (phase_q)
                        P_FETCH: begin
                            db_q    <= char_in;
                            rs_q    <= 1'b1;
                            clr_q   <= 1'b0;
                            phase_q <= P_SETUP;
                            cnt_q   <= '0;
                        end
                        P_SETUP: begin
                            if (cnt_q == SETUP_LAST) begin
                                e_q     <= 1'b1;
                                phase_q <= P_EHIGH;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        P_EHIGH: begin
                            if (cnt_q == EHIGH_LAST) begin
                                e_q     <= 1'b0;
                                phase_q <= P_WAIT;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        P_WAIT: begin
                            if (cnt_q == wait_last) begin
                                cnt_q <= '0;
                                // Write finished: choose the next write or return to IDLE
                                case (state_q)
                                    S_INIT: begin
                                        if (init_idx_q == 3'd5) begin
                                            state_q <= S_IDLE;
                                            busy_q  <= 1'b0;
                                        end else begin
                                            init_idx_q <= init_idx_q + 3'd1;
                                            db_q       <= init_cmd(init_idx_q + 3'd1);
                                            clr_q      <= (init_cmd(init_idx_q + 3'd1) == 8'h01);
                                            rs_q       <= 1'b0;
                                            phase_q    <= P_SETUP;
                                        end
                                    end
                                    S_ADDR1: begin
                                        state_q <= S_LINE1;
                                        phase_q <= P_FETCH;
                                    end
                                    S_LINE1: begin
                                        if (sel_q == 6'd15) begin
                                            sel_q   <= 6'd16;
                                            state_q <= S_ADDR2;
                                            rs_q    <= 1'b0;
                                            db_q    <= 8'hC0;
                                            clr_q   <= 1'b0;
                                            phase_q <= P_SETUP;
                                        end else begin
                                            sel_q   <= sel_q + 6'd1;
                                            phase_q <= P_FETCH;
                                        end
                                    end
                                    S_ADDR2: begin
                                        state_q <= S_LINE2;
                                        phase_q <= P_FETCH;
                                    end
                                    S_LINE2: begin
                                        if (sel_q == 6'd31) begin
                                            sel_q   <= '0;
                                            state_q <= S_IDLE;
                                            busy_q  <= 1'b0;
                                        end else begin
                                            sel_q   <= sel_q + 6'd1;
                                            phase_q <= P_FETCH;
                                        end
                                    end
                                    default: begin
                                        state_q <= S_IDLE;
                                        busy_q  <= 1'b0;
                                    end
                                endcase
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign sel    = sel_q;
    assign lcd_rs = rs_q;
    assign lcd_rw = 1'b0;
    assign lcd_e  = e_q;
    assign lcd_db = db_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_lcd_writer.sv
// Directed bench for lcd_writer: init sequence, refreshes, request merging,
// bus stability and reset during a write, with a behavioural lookup model.
module tb_lcd_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       buffer_ready = 1'b0;
    logic [7:0] char_in = 8'h00;
    logic [5:0] sel;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_db;
    logic       busy;

    lcd_writer #(
        .POWERUP_WAIT(20),
        .SETUP_CYC   (2),
        .E_PULSE     (3),
        .CMD_WAIT    (5),
        .CLEAR_WAIT  (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .buffer_ready(buffer_ready),
        .char_in     (char_in),
        .sel         (sel),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_e       (lcd_e),
        .lcd_db      (lcd_db),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Lookup model: data for the driven index is available within the next cycle
    always @(negedge clk) char_in <= 8'h41 + {2'b00, sel};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    int         cyc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    logic [8:0] pulses[$];
    int         rises[$];
    int         falls[$];
    int         widths[$];
    int         gaps[$];
    int         busy_fall = -1;
    int         stab_viol = 0;
    int         rw_viol   = 0;
    int         sel_viol  = 0;
    logic       e_prev    = 1'b0;
    logic       busy_prev = 1'b1;
    logic [8:0] hold_val  = '0;
    int         width     = 0;
    int         lowrun    = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            e_prev    = 1'b0;
            busy_prev = 1'b1;
            width     = 0;
            lowrun    = 0;
        end else begin
            if (lcd_rw !== 1'b0) rw_viol++;
            if (sel > 6'd31) sel_viol++;
            if (lcd_e && !e_prev) begin
                hold_val = {lcd_rs, lcd_db};
                pulses.push_back(hold_val);
                rises.push_back(cyc);
                width = 1;
            end else if (lcd_e && e_prev) begin
                width++;
                if ({lcd_rs, lcd_db} !== hold_val) stab_viol++;
            end else if (!lcd_e && e_prev) begin
                widths.push_back(width);
                falls.push_back(cyc);
            end
            if (!busy) lowrun++;
            else if (lowrun > 0) begin
                gaps.push_back(lowrun);
                lowrun = 0;
            end
            if (!busy && busy_prev) busy_fall = cyc;
            e_prev    = lcd_e;
            busy_prev = busy;
        end
    end

    localparam logic [7:0] INIT_SEQ [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};

    function automatic logic [8:0] exp_ref(input int i);
        if (i == 0)  return 9'h080;
        if (i < 17)  return 9'(9'h100 + 9'h041 + i - 1);
        if (i == 17) return 9'h0C0;
        return 9'(9'h100 + 9'h041 + i - 2);
    endfunction

    task automatic clear_mon();
        pulses.delete(); rises.delete(); falls.delete(); widths.delete(); gaps.delete();
    endtask

    task automatic wait_pulses(input int n, input int budget, input string tag);
        int k = 0;
        while (pulses.size() < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk(tag, 32'(pulses.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk(tag, 32'(busy), 0);
    endtask

    task automatic pulse_br();
        @(negedge clk); buffer_ready = 1'b1;
        @(negedge clk); @(negedge clk); buffer_ready = 1'b0;
    endtask

    task automatic check_init(input string pfx);
        wait_idle(400, {pfx, "_done"});
        chk({pfx, "_count"}, pulses.size(), 6);
        for (int i = 0; i < 6 && i < pulses.size(); i++) begin
            chk({pfx, "_cmd"}, pulses[i], {1'b0, INIT_SEQ[i]});
            if (i < widths.size()) chk({pfx, "_width"}, widths[i], 3);
        end
        if (rises.size() > 0) chk({pfx, "_first_rise"}, rises[0], 22);
        chk({pfx, "_busy_fall"}, busy_fall, 85);
        if (falls.size() > 0) chk({pfx, "_busy_after_e"}, busy_fall - falls[falls.size()-1], 10);
    endtask

    task automatic check_refreshes(input int nref, input string pfx);
        chk({pfx, "_count"}, pulses.size(), 34 * nref);
        for (int i = 0; i < 34 * nref && i < pulses.size(); i++)
            chk({pfx, "_data"}, pulses[i], exp_ref(i % 34));
        chk({pfx, "_sel"}, sel, 0);
        chk({pfx, "_busy"}, busy, 0);
    endtask

    initial begin
        int k;
        logic found;

        // Reset values
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_e", lcd_e, 0);
        chk("rst_sel", sel, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_db", lcd_db, 0);
        chk("rst_busy", busy, 1);
        chk("rst_rw", lcd_rw, 0);

        // Init sequence
        clear_mon();
        @(negedge clk); rst_n = 1'b1;
        check_init("init");

        // Single refresh
        clear_mon();
        pulse_br();
        wait_pulses(34, 1000, "ref1_reached");
        wait_idle(100, "ref1_idle");
        check_refreshes(1, "ref1");

        // Second edge during LINE1: exactly one extra refresh, 1-cycle IDLE gap
        clear_mon();
        pulse_br();
        wait_pulses(5, 200, "mid_start");
        gaps.delete();
        pulse_br();
        wait_pulses(68, 2000, "mid_reached");
        wait_idle(100, "mid_idle");
        check_refreshes(2, "mid");
        chk("mid_gap_count", gaps.size(), 1);
        if (gaps.size() > 0) chk("mid_gap_len", gaps[0], 1);
        repeat (100) @(negedge clk);
        #1;
        chk("mid_no_third", pulses.size(), 68);

        // Level-held request
        clear_mon();
        @(negedge clk); buffer_ready = 1'b1;
        wait_pulses(34, 1000, "lvl_reached");
        wait_idle(100, "lvl_idle");
        repeat (100) @(negedge clk);
        #1;
        check_refreshes(1, "lvl");

        // Reset during E-high of character sel=7
        buffer_ready = 1'b0;
        @(negedge clk); buffer_ready = 1'b1;
        k = 0;
        found = 1'b0;
        while (!found && k < 1000) begin
            @(negedge clk); #1;
            found = lcd_e && lcd_rs && (sel == 6'd7);
            k++;
        end
        chk("rstmid_reach", 32'(found), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_e", lcd_e, 0);
        chk("rstmid_sel", sel, 0);
        chk("rstmid_busy", busy, 1);
        buffer_ready = 1'b0;
        repeat (3) @(negedge clk);
        clear_mon();
        rst_n = 1'b1;
        check_init("reinit");

        chk("rs_db_stable", stab_viol, 0);
        chk("rw_zero", rw_viol, 0);
        chk("sel_range", sel_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
